// File: rtl/mips_bus_mem_responder.sv
// Memory-side responder for the CPU word bus: word-wide RAM at ADDR_BASE,
// WAIT_CYCLES wait states per transfer, sticky error flag for bad accesses.
module mips_bus_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'hBFC0_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [WW-1:0] WMAX = WW'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  logic [31:0]   mem [MEM_WORDS];
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  state_e        state;
  logic          req, complete, aligned, in_range, bad, wr_ok, rd_ok;
  logic [29:0]   idx;
  logic [AW-1:0] widx;

  // RAM starts all zeros.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  end

  // Address decode: offset from base wraps at 32 bits, word index is offset/4.
  always_comb begin
    idx      = 30'((address - ADDR_BASE) >> 2);
    widx     = idx[AW-1:0];
    in_range = 32'(idx) < 32'(MEM_WORDS);
    aligned  = (address[1:0] == 2'b00);
  end

  // Transfer phase and next wait count; the counter itself is the FSM state.
  always_comb begin
    req    = read | write;
    state  = S_IDLE;
    wcnt_d = '0;
    if (req) begin
      if (wcnt_q < WMAX) begin
        state  = S_WAIT;
        wcnt_d = WW'(wcnt_q + 1'b1);
      end else begin
        state  = S_DONE;
      end
    end
    waitrequest = reset | (state == S_WAIT);
    complete    = !reset && (state == S_DONE);
    bad         = !in_range || !aligned || (read && write);
    wr_ok       = complete && write && !read && in_range && aligned;
    rd_ok       = complete && read && !write && in_range && aligned;
    readdata    = rd_ok ? mem[widx] : 32'h0;
    err_d       = err_q | (complete & bad);
    err         = err_q;
  end

  // Wait counter and sticky error flag; reset drops any pending transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  // RAM byte-lane writes, committed only at the completing edge.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[widx][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Bench for mips_bus_mem_responder: four instances with 0/2/3/4 wait states,
// one selected at a time; a monitor checks completions against a queue.
module tb_mips_bus_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writedata;
  logic        read, write;
  logic [3:0]  byteenable;
  int          sel;

  logic [3:0]       wq, errv;
  logic [3:0][31:0] rdv;

  typedef struct {
    logic [31:0] rd;
    int          waits;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mips_bus_mem_responder #(
      .ADDR_BASE  (32'hBFC0_0000),
      .MEM_WORDS  (1024),
      .WAIT_CYCLES((g == 0) ? 0 : g + 1),
      .INIT_FILE  ("")
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .read       (read & (sel == g)),
      .write      (write & (sel == g)),
      .writedata  (writedata),
      .byteenable (byteenable),
      .waitrequest(wq[g]),
      .readdata   (rdv[g]),
      .err        (errv[g])
    );
  end

  // Monitor: counts wait cycles per transfer, pops expectation on completion.
  initial begin
    int   wc = 0;
    bit   chk = 0;
    logic ce = 0;
    int   ck = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk) begin
        total++;
        if (errv[ck] !== ce) begin
          bad++;
          $display("FAIL err_after_xfer dut=%0d got=%b want=%b", ck, errv[ck], ce);
        end
        chk = 0;
      end
      if (reset) begin
        wc = 0;
        total++;
        if (wq[sel] !== 1'b1 || rdv[sel] !== 32'h0) begin
          bad++;
          $display("FAIL reset_outputs dut=%0d waitreq=%b readdata=%h want 1/0", sel, wq[sel], rdv[sel]);
        end
      end else if (read | write) begin
        if (wq[sel]) wc++;
        else begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_completion dut=%0d readdata=%h", sel, rdv[sel]);
          end else begin
            e = exp_q.pop_front();
            if (rdv[sel] !== e.rd || wc != e.waits) begin
              bad++;
              $display("FAIL completion dut=%0d addr=%h readdata=%h waits=%0d want readdata=%h waits=%0d",
                       sel, address, rdv[sel], wc, e.rd, e.waits);
            end
            chk = 1; ce = e.err; ck = sel;
          end
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  task automatic idle(input int n);
    read = 0; write = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transfer on the selected DUT, held until waitrequest drops.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] er, input int ew, input logic ee);
    exp_t e;
    logic w;
    e.rd = er; e.waits = ew; e.err = ee;
    exp_q.push_back(e);
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      w = wq[sel];
      @(posedge clk);
      #1;
      if (!w) break;
      if (n > 30) begin
        total++; bad++;
        $display("FAIL timeout dut=%0d addr=%h waitrequest stuck high", sel, a);
        break;
      end
    end
    read = 0; write = 0;
  endtask

  task automatic pulse_reset;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    total++;
    if (errv[sel] !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared_by_reset dut=%0d got=%b want=0", sel, errv[sel]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; read = 0; write = 0; address = 32'hBFC0_0000;
    writedata = 0; byteenable = 0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // WAIT=0: single-cycle write then read
    sel = 0;
    xfer(0, 1, 32'hBFC0_0004, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
    xfer(1, 0, 32'hBFC0_0004, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);
    // byte lanes
    xfer(0, 1, 32'hBFC0_0008, 32'h11223344, 4'hF, 32'h0, 0, 0);
    xfer(0, 1, 32'hBFC0_0008, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0);
    xfer(1, 0, 32'hBFC0_0008, 32'h0, 4'h0, 32'h11BB33DD, 0, 0);
    xfer(0, 1, 32'hBFC0_0008, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 0);
    xfer(1, 0, 32'hBFC0_0008, 32'h0, 4'hF, 32'h11BB33DD, 0, 0);
    idle(1);
    // errors
    xfer(1, 0, 32'hBFC0_1000, 32'h0, 4'h0, 32'h0, 0, 1);
    idle(1);
    pulse_reset();
    xfer(0, 1, 32'hBFC0_0002, 32'h12345678, 4'hF, 32'h0, 0, 1);
    idle(1);
    pulse_reset();
    xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'h0, 32'h0, 0, 0);
    xfer(1, 0, 32'hBFC0_0004, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);
    xfer(1, 1, 32'hBFC0_0004, 32'h0, 4'hF, 32'h0, 0, 1);
    xfer(1, 0, 32'hBFC0_0004, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1);
    xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 0, 1);
    idle(1);
    pulse_reset();

    // WAIT=3: held reads, back-to-back repeats the full wait
    sel = 2;
    idle(1);
    xfer(0, 1, 32'hBFC0_0000, 32'hCAFEF00D, 4'hF, 32'h0, 3, 0);
    xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'h0, 32'hCAFEF00D, 3, 0);
    xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'h0, 32'hCAFEF00D, 3, 0);
    idle(2);

    // WAIT=2: reset during 2nd wait cycle of a write
    sel = 1;
    idle(1);
    address = 32'hBFC0_0010; writedata = 32'h55555555; byteenable = 4'hF;
    write = 1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; write = 0;
    idle(1);
    xfer(1, 0, 32'hBFC0_0010, 32'h0, 4'h0, 32'h0, 2, 0);
    xfer(0, 1, 32'hBFC0_0FFC, 32'h0BADC0DE, 4'hF, 32'h0, 2, 0);
    xfer(1, 0, 32'hBFC0_0FFC, 32'h0, 4'h0, 32'h0BADC0DE, 2, 0);
    idle(2);

    // WAIT=4: abandon after two cycles, re-raise waits the full four again
    sel = 3;
    idle(1);
    address = 32'hBFC0_0000; read = 1;
    repeat (2) @(posedge clk);
    #1;
    idle(1);
    xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'h0, 32'h0, 4, 0);
    idle(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
